mat_cache_seq: RTL and testbench

MAT_CACHE_SEQ -- requirements
Module: mat_cache_seq

---
 rtl/mat_pkg.sv | 70 +++++++
 rtl/mat_seq_counter.sv | 29 ++
 rtl/mat_cache_seq.sv | 151 +++++++++++++++
 tb/tb_mat_cache_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared types for the matrix cache and its command sequencer.
package mat_pkg;

    // Write controls understood by the matrix cache.
    typedef enum logic [2:0] {
        WRITE_DISABLE   = 3'd0,
        WRITE_ROW       = 3'd1,
        WRITE_COL       = 3'd2,
        WRITE_DIAG      = 3'd3,
        WRITE_TRANSPOSE = 3'd4
    } MatDataWriteOp_t;

    // Read controls understood by the matrix cache.
    typedef enum logic [1:0] {
        READ_ROW  = 2'd0,
        READ_COL  = 2'd1,
        READ_DIAG = 2'd2
    } MatDataReadOp_t;

    // Commands accepted by the sequencer.
    typedef enum logic [2:0] {
        LOAD_ROW   = 3'd0,
        LOAD_COL   = 3'd1,
        LOAD_DIAG  = 3'd2,
        STORE_ROW  = 3'd3,
        STORE_COL  = 3'd4,
        STORE_DIAG = 3'd5,
        TRANSPOSE  = 3'd6
    } MatSeqOp_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        XPOSE = 2'd3
    } MatSeqState_t;

    function automatic logic is_load_op(input MatSeqOp_t op);
        return (op == LOAD_ROW) || (op == LOAD_COL) || (op == LOAD_DIAG);
    endfunction

    function automatic logic is_store_op(input MatSeqOp_t op);
        return (op == STORE_ROW) || (op == STORE_COL) || (op == STORE_DIAG);
    endfunction

    function automatic logic is_diag_op(input MatSeqOp_t op);
        return (op == LOAD_DIAG) || (op == STORE_DIAG);
    endfunction

    // Cache write control used for each accepted load beat.
    function automatic MatDataWriteOp_t load_write_op(input MatSeqOp_t op);
        case (op)
            LOAD_ROW:  return WRITE_ROW;
            LOAD_COL:  return WRITE_COL;
            LOAD_DIAG: return WRITE_DIAG;
            default:   return WRITE_DISABLE;
        endcase
    endfunction

    // Cache read control presented during a store.
    function automatic MatDataReadOp_t store_read_op(input MatSeqOp_t op);
        case (op)
            STORE_COL:  return READ_COL;
            STORE_DIAG: return READ_DIAG;
            default:    return READ_ROW;
        endcase
    endfunction

endpackage

// File: rtl/mat_seq_counter.sv
// Beat counter for the sequencer: counts 0..WIDTH-1, wraps on the last beat.
module mat_seq_counter
    import mat_pkg::*;
#(
    parameter int WIDTH = 128,
    localparam int WA = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [WA-1:0] count,
    output logic          last
);

    assign last = (count == WA'(WIDTH - 1));

    // Clear wins over a beat; a beat on the last position wraps back to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/mat_cache_seq.sv
// Command sequencer for the matrix cache: turns row/column/diagonal load and
// store commands into WIDTH-beat streams of cache controls, and transposes in
// a single cycle.
module mat_cache_seq
    import mat_pkg::*;
#(
    parameter int WIDTH      = 128,
    parameter int CACHE_SIZE = 4,
    localparam int WA = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int CA = (CACHE_SIZE > 1) ? $clog2(CACHE_SIZE) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  MatSeqOp_t       cmd_op,
    input  logic [CA-1:0]   cmd_addr1,
    input  logic [CA-1:0]   cmd_addr2,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output MatDataWriteOp_t write_op,
    output logic [CA-1:0]   write_addr1,
    output logic [CA-1:0]   write_addr2,
    output logic [WA-1:0]   write_param,
    output MatDataReadOp_t  read_op,
    output logic [CA-1:0]   read_addr1,
    output logic [CA-1:0]   read_addr2,
    output logic [WA-1:0]   read_param,
    output logic            busy,
    output logic            done,
    output logic            cmd_err
);

    MatSeqState_t  state;
    MatSeqState_t  state_nxt;
    MatSeqOp_t     op_q;
    logic [CA-1:0] addr1_q;
    logic [CA-1:0] addr2_q;
    logic          done_q;
    logic          err_q;

    logic          accept;
    logic          bad_diag;
    logic          beat;
    logic [WA-1:0] beat_cnt;
    logic          beat_last;

    // A diagonal op needs two distinct slots; equal slots are rejected.
    assign bad_diag = is_diag_op(cmd_op) && (cmd_addr1 == cmd_addr2);

    mat_seq_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clock (clock),
        .reset (reset),
        .clr   (accept),
        .en    (beat),
        .count (beat_cnt),
        .last  (beat_last)
    );

    // State, latched command and the one-cycle status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= LOAD_ROW;
            addr1_q <= '0;
            addr2_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state != IDLE) && (state_nxt == IDLE);
            err_q  <= accept && bad_diag;
            if (accept && !bad_diag) begin
                op_q    <= cmd_op;
                addr1_q <= cmd_addr1;
                addr2_q <= cmd_addr2;
            end
        end
    end

    // Next state and cache controls, straight from state, counter and handshakes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        beat      = 1'b0;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        write_op  = WRITE_DISABLE;
        read_op   = READ_ROW;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (!bad_diag) begin
                        if (is_load_op(cmd_op)) begin
                            state_nxt = LOAD;
                        end else if (is_store_op(cmd_op)) begin
                            state_nxt = STORE;
                        end else if (cmd_op == TRANSPOSE) begin
                            state_nxt = XPOSE;
                        end
                    end
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    beat     = 1'b1;
                    write_op = load_write_op(op_q);
                    if (beat_last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            STORE: begin
                out_valid = 1'b1;
                read_op   = store_read_op(op_q);
                if (out_ready) begin
                    beat = 1'b1;
                    if (beat_last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            XPOSE: begin
                write_op  = WRITE_TRANSPOSE;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign write_addr1 = addr1_q;
    assign write_addr2 = addr2_q;
    assign read_addr1  = addr1_q;
    assign read_addr2  = addr2_q;
    assign write_param = beat_cnt;
    assign read_param  = beat_cnt;
    assign busy        = (state != IDLE);
    assign done        = done_q;
    assign cmd_err     = err_q;

endmodule

// File: tb/tb_mat_cache_seq.sv
// Bench for mat_cache_seq with WIDTH=4, CACHE_SIZE=4: a small behavioural
// cache reacts to the sequencer's controls, and a command-level reference
// matrix store supplies the expected data.
module tb_mat_cache_seq;
    import mat_pkg::*;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    MatSeqOp_t       cmd_op = LOAD_ROW;
    logic [1:0]      cmd_addr1 = '0;
    logic [1:0]      cmd_addr2 = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready = 1'b0;
    MatDataWriteOp_t write_op;
    logic [1:0]      write_addr1, write_addr2, write_param;
    MatDataReadOp_t  read_op;
    logic [1:0]      read_addr1, read_addr2, read_param;
    logic            busy, done, cmd_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] din = '0;
    logic [31:0] dout;
    logic [7:0]  mem   [4][4][4];
    logic [7:0]  ref_m [4][4][4];
    logic [31:0] ld_v  [4];
    logic [31:0] exp_v [4];
    logic [31:0] got_v [4];
    logic [31:0] col_v [4];
    logic [31:0] diag_v[4];
    int          pat[$];
    int          params[$];

    mat_cache_seq #(.WIDTH(4), .CACHE_SIZE(4)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr1(cmd_addr1), .cmd_addr2(cmd_addr2),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .write_op(write_op), .write_addr1(write_addr1), .write_addr2(write_addr2),
        .write_param(write_param),
        .read_op(read_op), .read_addr1(read_addr1), .read_addr2(read_addr2),
        .read_param(read_param),
        .busy(busy), .done(done), .cmd_err(cmd_err)
    );

    always #5 clock = ~clock;

    // Behavioural cache: diagonal p holds element k at (row k, col (k+p) mod 4).
    always @(posedge clock) begin
        for (int k = 0; k < 4; k++) begin
            case (write_op)
                WRITE_ROW:  mem[write_addr1][write_param][2'(k)] <= din[8*k +: 8];
                WRITE_COL:  mem[write_addr1][2'(k)][write_param] <= din[8*k +: 8];
                WRITE_DIAG: mem[write_addr1][2'(k)][2'(k) + write_param] <= din[8*k +: 8];
                WRITE_TRANSPOSE:
                    for (int c = 0; c < 4; c++) mem[write_addr1][2'(k)][2'(c)] <= mem[write_addr1][2'(c)][2'(k)];
                default: ;
            endcase
        end
    end

    always_comb begin
        dout = '0;
        for (int k = 0; k < 4; k++) begin
            if (read_op == READ_COL)       dout[8*k +: 8] = mem[read_addr1][2'(k)][read_param];
            else if (read_op == READ_DIAG) dout[8*k +: 8] = mem[read_addr1][2'(k)][2'(k) + read_param];
            else                           dout[8*k +: 8] = mem[read_addr1][read_param][2'(k)];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] row_of(input int a, input int p);
        return {ref_m[a][p][3], ref_m[a][p][2], ref_m[a][p][1], ref_m[a][p][0]};
    endfunction

    function automatic logic [31:0] col_of(input int a, input int p);
        return {ref_m[a][3][p], ref_m[a][2][p], ref_m[a][1][p], ref_m[a][0][p]};
    endfunction

    task automatic rand_vecs();
        for (int b = 0; b < 4; b++) ld_v[b] = $urandom;
    endtask

    // Offer one command at the drive point; returns one cycle later.
    task automatic do_cmd(input MatSeqOp_t op, input logic [1:0] a1, input logic [1:0] a2, input string tag);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr1 = a1; cmd_addr2 = a2;
        #1;
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    // Stream ld_v[0..3] with in_valid held high.
    task automatic load_seq(input MatDataWriteOp_t wop, input logic [1:0] a1, input string tag);
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b1; din = ld_v[b];
            #1;
            check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            check({tag, "_write_op"}, 32'(write_op), 32'(wop));
            check({tag, "_write_param"}, 32'(write_param), 32'(b));
            check({tag, "_write_addr1"}, 32'(write_addr1), 32'(a1));
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        #1;
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_wop_idle"}, 32'(write_op), 32'(WRITE_DISABLE));
        @(posedge clock); #1;
        check({tag, "_done_once"}, 32'(done), 32'd0);
    endtask

    // Collect four vectors; mode 1 takes out_ready from pat, mode 0 is random.
    task automatic store_seq(input MatDataReadOp_t rop, input logic [1:0] a1, input int mode, input string tag);
        int beats = 0;
        int cyc = 0;
        params.delete();
        while (beats < 4 && cyc < 40) begin
            if (mode == 1) out_ready = (cyc < pat.size()) ? pat[cyc][0] : 1'b1;
            else           out_ready = 1'($urandom_range(0, 1));
            #1;
            check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_read_op"}, 32'(read_op), 32'(rop));
            check({tag, "_read_param"}, 32'(read_param), 32'(beats));
            check({tag, "_read_addr1"}, 32'(read_addr1), 32'(a1));
            params.push_back(int'(read_param));
            if (out_ready) begin
                check({tag, "_data"}, dout, exp_v[beats]);
                got_v[beats] = dout;
                beats++;
            end
            @(posedge clock); #1;
            cyc++;
        end
        check({tag, "_beats"}, 32'(beats), 32'd4);
        out_ready = 1'b0;
        #1;
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_rop_idle"}, 32'(read_op), 32'(READ_ROW));
        @(posedge clock); #1;
        check({tag, "_done_once"}, 32'(done), 32'd0);
    endtask

    initial begin
        // Reset state, while asserted and right after release.
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_write_op", 32'(write_op), 32'(WRITE_DISABLE));
        check("rst_done", 32'(done), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        check("rst_param", 32'(write_param), 32'd0);
        check("rst_addr1", 32'(write_addr1), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_done", 32'(done), 32'd0);

        // LOAD_ROW slot 2.
        rand_vecs();
        do_cmd(LOAD_ROW, 2'd2, 2'd0, "ldrow2");
        load_seq(WRITE_ROW, 2'd2, "ldrow2");
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 4; k++) ref_m[2][p][k] = ld_v[p][8*k +: 8];
        for (int p = 0; p < 4; p++)
            check("ldrow2_cache_row", {mem[2][p][3], mem[2][p][2], mem[2][p][1], mem[2][p][0]}, ld_v[p]);

        // LOAD_ROW slot 1, then STORE_COL slot 1 with a stalling consumer.
        rand_vecs();
        do_cmd(LOAD_ROW, 2'd1, 2'd0, "ldrow1");
        load_seq(WRITE_ROW, 2'd1, "ldrow1");
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 4; k++) ref_m[1][p][k] = ld_v[p][8*k +: 8];
        for (int p = 0; p < 4; p++) exp_v[p] = col_of(1, p);
        pat = '{1, 0, 1, 1, 0, 1};
        do_cmd(STORE_COL, 2'd1, 2'd0, "stcol1");
        store_seq(READ_COL, 2'd1, 1, "stcol1");
        begin
            int exp_params[6] = '{0, 1, 1, 2, 3, 3};
            check("stcol1_nparams", 32'(params.size()), 32'd6);
            for (int i = 0; i < 6 && i < params.size(); i++)
                check("stcol1_param_seq", 32'(params[i]), 32'(exp_params[i]));
        end

        // LOAD_DIAG 0/1 then STORE_DIAG returns the same vectors.
        rand_vecs();
        for (int p = 0; p < 4; p++) diag_v[p] = ld_v[p];
        do_cmd(LOAD_DIAG, 2'd0, 2'd1, "lddiag");
        #1 check("lddiag_addr2", 32'(write_addr2), 32'd1);
        load_seq(WRITE_DIAG, 2'd0, "lddiag");
        for (int p = 0; p < 4; p++) exp_v[p] = diag_v[p];
        do_cmd(STORE_DIAG, 2'd0, 2'd1, "stdiag");
        #1 check("stdiag_addr2", 32'(read_addr2), 32'd1);
        store_seq(READ_DIAG, 2'd0, 0, "stdiag");

        // Diagonal op on a single slot is rejected.
        do_cmd(LOAD_DIAG, 2'd3, 2'd3, "baddiag");
        #1;
        check("baddiag_cmd_err", 32'(cmd_err), 32'd1);
        check("baddiag_busy", 32'(busy), 32'd0);
        check("baddiag_write_op", 32'(write_op), 32'(WRITE_DISABLE));
        check("baddiag_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        check("baddiag_err_once", 32'(cmd_err), 32'd0);
        check("baddiag_busy2", 32'(busy), 32'd0);

        // STORE_COL slot 2, TRANSPOSE slot 2, STORE_ROW slot 2 matches the columns.
        for (int p = 0; p < 4; p++) exp_v[p] = col_of(2, p);
        do_cmd(STORE_COL, 2'd2, 2'd0, "stcol2");
        store_seq(READ_COL, 2'd2, 0, "stcol2");
        for (int p = 0; p < 4; p++) col_v[p] = got_v[p];
        do_cmd(TRANSPOSE, 2'd2, 2'd0, "xpose2");
        #1;
        check("xpose2_write_op", 32'(write_op), 32'(WRITE_TRANSPOSE));
        check("xpose2_addr1", 32'(write_addr1), 32'd2);
        check("xpose2_busy", 32'(busy), 32'd1);
        @(posedge clock); #1;
        check("xpose2_done", 32'(done), 32'd1);
        check("xpose2_single", 32'(write_op), 32'(WRITE_DISABLE));
        check("xpose2_idle", 32'(busy), 32'd0);
        @(posedge clock); #1;
        for (int r = 0; r < 4; r++) exp_v[r] = col_of(2, r);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) ref_m[2][r][c] = exp_v[r][8*c +: 8];
        do_cmd(STORE_ROW, 2'd2, 2'd0, "strow2");
        store_seq(READ_ROW, 2'd2, 0, "strow2");
        for (int p = 0; p < 4; p++) check("strow2_eq_col", got_v[p], col_v[p]);

        // Fill slot 3, then abort a LOAD_COL with reset after two beats.
        rand_vecs();
        do_cmd(LOAD_ROW, 2'd3, 2'd0, "ldrow3");
        load_seq(WRITE_ROW, 2'd3, "ldrow3");
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 4; k++) ref_m[3][p][k] = ld_v[p][8*k +: 8];
        rand_vecs();
        do_cmd(LOAD_COL, 2'd3, 2'd0, "ldcol3");
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1; din = ld_v[b];
            #1;
            check("ldcol3_write_op", 32'(write_op), 32'(WRITE_COL));
            check("ldcol3_param", 32'(write_param), 32'(b));
            @(posedge clock); #1;
        end
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < 4; k++) ref_m[3][k][b] = ld_v[b][8*k +: 8];
        in_valid = 1'b1; din = ld_v[2]; reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_write_op", 32'(write_op), 32'(WRITE_DISABLE));
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(posedge clock); #1;
        check("abort_col2_kept", {mem[3][3][2], mem[3][2][2], mem[3][1][2], mem[3][0][2]}, col_of(3, 2));
        check("abort_col1_written", {mem[3][3][1], mem[3][2][1], mem[3][1][1], mem[3][0][1]}, col_of(3, 1));
        reset = 1'b0; in_valid = 1'b0;
        @(posedge clock); #1;
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        for (int p = 0; p < 4; p++) exp_v[p] = row_of(3, p);
        do_cmd(STORE_ROW, 2'd3, 2'd0, "strow3");
        store_seq(READ_ROW, 2'd3, 0, "strow3");

        // A command offered during TRANSPOSE is held off, then accepted.
        do_cmd(TRANSPOSE, 2'd3, 2'd0, "xpose3");
        cmd_valid = 1'b1; cmd_op = STORE_ROW; cmd_addr1 = 2'd3; cmd_addr2 = 2'd0;
        #1;
        check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        check("hold_write_op", 32'(write_op), 32'(WRITE_TRANSPOSE));
        @(posedge clock); #1;
        check("hold_accept_ready", 32'(cmd_ready), 32'd1);
        check("hold_done", 32'(done), 32'd1);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        for (int p = 0; p < 4; p++) exp_v[p] = col_of(3, p);
        store_seq(READ_ROW, 2'd3, 0, "held_strow3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
